serial_compare_ctl: RTL



---
 rtl/serial_compare_ctl_pkg.sv | 13 +
 rtl/serial_compare_ctl_if.sv | 35 +++
 rtl/serial_compare_ctl_slice.sv | 37 +++
 rtl/serial_compare_ctl.sv | 115 +++++++++++
 4 files changed

// File: rtl/serial_compare_ctl_pkg.sv
// Shared definitions for the serial magnitude comparator.
//   state_t          : controller FSM encoding (ST_IDLE, ST_RUN)
//   CMP_SEED         : cascade value loaded at start ({gt,lt,eq} = 001)
//   CAS_GT/LT/EQ     : bit positions inside a 3-bit cascade vector
package cmp_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam int CAS_GT = 2;
  localparam int CAS_LT = 1;
  localparam int CAS_EQ = 0;

  localparam logic [2:0] CMP_SEED = 3'b001;
endpackage

// File: rtl/serial_compare_ctl_if.sv
// Start/done handshake bus of serial_compare_ctl.
//   start, a, b   : request and operands (requester -> comparator)
//   sgn           : signed-compare select, only with SERIAL_COMPARE_SIGNED_EN
//   busy, done    : run status and one-cycle result strobe
//   lt, eq, gt    : held result flags
// Modports: master = requester side, slave = comparator side.
interface serial_compare_ctl_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_COMPARE_SIGNED_EN
  logic             sgn;
`endif
  logic             busy;
  logic             done;
  logic             lt;
  logic             eq;
  logic             gt;

  modport master (
`ifdef SERIAL_COMPARE_SIGNED_EN
    output sgn,
`endif
    output start, a, b,
    input  busy, done, lt, eq, gt
  );

  modport slave (
`ifdef SERIAL_COMPARE_SIGNED_EN
    input  sgn,
`endif
    input  start, a, b,
    output busy, done, lt, eq, gt
  );
endinterface

// File: rtl/serial_compare_ctl_slice.sv
// nibble_compare_slice: combinational 4-bit magnitude slice with
// 74x85 cascade semantics.
//   a, b  : nibble operands
//   cin   : cascade in  {gt,lt,eq} (positions from cmp_pkg)
//   cout  : cascade out {gt,lt,eq}
module nibble_compare_slice
  import cmp_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] cin,
  output logic [2:0] cout
);
  always_comb begin
    cout = '0;
    if (a > b) begin
      cout[CAS_GT] = 1'b1;
    end else if (a < b) begin
      cout[CAS_LT] = 1'b1;
    end else if (cin[CAS_EQ]) begin
      cout[CAS_EQ] = 1'b1;
    end else begin
      // Equal nibble, no eq cascade: 74x85 quirks for 00 and 11.
      unique case ({cin[CAS_GT], cin[CAS_LT]})
        2'b00: begin
          cout[CAS_GT] = 1'b1;
          cout[CAS_LT] = 1'b1;
        end
        2'b11: cout = '0;
        default: begin
          cout[CAS_GT] = cin[CAS_GT];
          cout[CAS_LT] = cin[CAS_LT];
        end
      endcase
    end
  end
endmodule

// File: rtl/serial_compare_ctl.sv
// serial_compare_ctl: WIDTH-bit magnitude comparator built from one
// 4-bit slice, walked LSB nibble first over WIDTH/4 clocks with the slice
// result fed back as the next cascade input.
//   clk, nreset : clock (rising edge), async active-low reset
//   bus (slave) : start/a/b in, busy/done/lt/eq/gt out
// Optional: SERIAL_COMPARE_SIGNED_EN adds bus.sgn for two's-complement compare.
module serial_compare_ctl
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                nreset,
  serial_compare_ctl_if.slave bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  generate
    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("serial_compare_ctl: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ra, rb;
  logic [2:0]       cas, slice_out;
  logic [3:0]       na, nb;
  logic             accept, last;
`ifdef SERIAL_COMPARE_SIGNED_EN
  logic             rsgn;
`endif

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // Next state
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (bus.start) state_nx = ST_RUN;
      ST_RUN:  if (last)      state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    accept   = (state == ST_IDLE) && bus.start;
    last     = (state == ST_RUN) && (cnt == CW'(NIBBLES - 1));
    bus.busy = (state == ST_RUN);
  end

  // Operands are shifted right one nibble per step, so the live nibble
  // always sits in bits [3:0] and no wide mux is needed.
  always_comb begin
    na = ra[3:0];
    nb = rb[3:0];
`ifdef SERIAL_COMPARE_SIGNED_EN
    // Flipping both sign bits maps two's complement onto unsigned order.
    if (last && rsgn) begin
      na[3] = ~na[3];
      nb[3] = ~nb[3];
    end
`endif
  end

  nibble_compare_slice u_slice (
    .a    (na),
    .b    (nb),
    .cin  (cas),
    .cout (slice_out)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt      <= '0;
      ra       <= '0;
      rb       <= '0;
      cas      <= '0;
      bus.done <= 1'b0;
      bus.lt   <= 1'b0;
      bus.eq   <= 1'b0;
      bus.gt   <= 1'b0;
`ifdef SERIAL_COMPARE_SIGNED_EN
      rsgn     <= 1'b0;
`endif
    end else begin
      bus.done <= last;
      if (accept) begin
        ra  <= bus.a;
        rb  <= bus.b;
        cas <= CMP_SEED;
        cnt <= '0;
`ifdef SERIAL_COMPARE_SIGNED_EN
        rsgn <= bus.sgn;
`endif
      end else if (state == ST_RUN) begin
        ra  <= ra >> 4;
        rb  <= rb >> 4;
        cas <= slice_out;
        cnt <= cnt + CW'(1);
        if (last) begin
          bus.gt <= slice_out[CAS_GT];
          bus.lt <= slice_out[CAS_LT];
          bus.eq <= slice_out[CAS_EQ];
        end
      end
    end
  end
endmodule
